// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO write-side blocks.
//   state_e : arbiter FSM state encoding (ST_IDLE / ST_BURST)
//   clog2   : ceiling log2 used for index and counter widths
package fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // clog2(0) and clog2(1) both return 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: bundle between the write-domain requesters and the FIFO write port.
//   req/last/data : per-requester request, end-of-burst marker, packed data
//   full          : FIFO full flag from the write-pointer handler
//   w_en/wdata    : FIFO write port
//   gnt/owner/busy: per-beat accept strobe, current/last owner, burst in progress
// master = arbiter side, slave = requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    import fifo_pkg::*;

    localparam int unsigned OW = (NREQ > 1) ? clog2(NREQ) : 1;

    logic [NREQ-1:0]            req;
    logic [NREQ-1:0]            last;
    logic [NREQ*DATA_WIDTH-1:0] data;
    logic                       full;
    logic                       w_en;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [NREQ-1:0]            gnt;
    logic [OW-1:0]              owner;
    logic                       busy;

    modport master (
        input  req, last, data, full,
        output w_en, wdata, gnt, owner, busy
    );

    modport slave (
        output req, last, data, full,
        input  w_en, wdata, gnt, owner, busy
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority selector.
//   req    : request vector
//   rr_ptr : highest-priority index; search order rr_ptr, rr_ptr+1, ... modulo NREQ
//   valid  : any request set
//   index  : first set request in search order (0 when none)
module rr_pick
    import fifo_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]                         req,
    input  logic [((NREQ > 1) ? clog2(NREQ) : 1)-1:0] rr_ptr,
    output logic                                    valid,
    output logic [((NREQ > 1) ? clog2(NREQ) : 1)-1:0] index
);

    localparam int unsigned PW = (NREQ > 1) ? clog2(NREQ) : 1;

    // One extra bit so rr_ptr + offset never overflows before the wrap compare.
    logic [PW:0] cand;

    // Walk from the lowest priority to the highest so the last hit wins.
    always_comb begin
        valid = |req;
        index = '0;
        cand  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (PW + 1)'(i);
            if (cand >= (PW + 1)'(NREQ)) begin
                cand = cand - (PW + 1)'(NREQ);
            end
            if (req[cand[PW-1:0]]) begin
                index = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the FIFO write port among NREQ
// write-domain requesters. A granted requester owns the port for up to MAX_BURST
// accepted beats; bursts are separated by a single IDLE arbitration cycle.
//   wclk   : write-domain clock
//   wrst_n : asynchronous active-low reset
//   bus    : fifo_wr_arbiter_if master modport (req/last/data/full in,
//            w_en/wdata/gnt/owner/busy out)
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic              wclk,
    input  logic              wrst_n,
    fifo_wr_arbiter_if.master bus
);

    localparam int unsigned OW = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int unsigned BW = clog2(MAX_BURST) + 1;

    state_e          state_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   rr_ptr_q;
    logic [BW-1:0]   beat_cnt_q;
    logic            busy_q;

    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic [OW-1:0]   owner_next;
    logic            accept;
    logic            burst_end;
    logic            w_en;
    logic [NREQ-1:0] gnt;
    logic [DATA_WIDTH-1:0] wdata;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    // Explicit wrap keeps non-power-of-2 NREQ correct.
    assign owner_next = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // Write port is combinational on the owner's live request and full, so a
    // stalled beat is retried the very cycle full drops.
    always_comb begin
        accept    = 1'b0;
        burst_end = 1'b0;
        w_en      = 1'b0;
        gnt       = '0;
        wdata     = '0;
        if (state_q == ST_BURST) begin
            accept       = bus.req[owner_q] & ~bus.full;
            w_en         = accept;
            gnt[owner_q] = accept;
            wdata        = bus.data[owner_q*DATA_WIDTH +: DATA_WIDTH];
            // A dropped request abandons the burst without writing.
            burst_end    = ~bus.req[owner_q] |
                           (accept & (bus.last[owner_q] |
                                      (beat_cnt_q == BW'(MAX_BURST - 1))));
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_q    <= pick_idx;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                    if (burst_end) begin
                        rr_ptr_q <= owner_next;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.w_en  = w_en;
    assign bus.gnt   = gnt;
    assign bus.wdata = wdata;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench for fifo_wr_arbiter (NREQ=4, 8-bit data,
// MAX_BURST=4). Directed table, hand-written corner sequences and a randomized run
// checked against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;

    logic wclk;
    logic wrst_n;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NREQ       (NREQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: who owns the port, how many beats it has written,
    // and where the next round-robin search begins.
    int m_owner;
    int m_ptr;
    int m_beats;
    bit m_busy;
    int wr_cnt[NREQ];

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic       full;
        logic       e_wen;
        logic [3:0] e_gnt;
        logic [1:0] e_owner;
        logic       e_busy;
        logic [7:0] e_wdata;
    } vec_t;

    vec_t tbl[10];

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_ptr   = 0;
        m_beats = 0;
        m_busy  = 0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NREQ; i++) wr_cnt[i] = 0;
    endtask

    task automatic check_model();
        logic       acc;
        logic [3:0] eg;
        logic [7:0] ed;
        acc = m_busy && bus.req[m_owner] && !bus.full;
        eg  = acc ? 4'(1 << m_owner) : 4'b0000;
        ed  = m_busy ? bus.data[m_owner*DW +: DW] : 8'h00;
        chk("w_en",  32'(bus.w_en),  32'(acc));
        chk("gnt",   32'(bus.gnt),   32'(eg));
        chk("wdata", 32'(bus.wdata), 32'(ed));
        chk("owner", 32'(bus.owner), 32'(m_owner));
        chk("busy",  32'(bus.busy),  32'(m_busy));
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i] === 1'b1) wr_cnt[i]++;
        end
    endtask

    task automatic model_advance();
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (bus.req[i]) begin
                    m_owner = i;
                    m_beats = 0;
                    m_busy  = 1;
                    break;
                end
            end
        end else if (!bus.req[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NREQ;
        end else if (!bus.full) begin
            m_beats++;
            if (bus.last[m_owner] || m_beats == MB) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % NREQ;
            end
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic f,
                         input logic [31:0] d);
        bus.req  = r;
        bus.last = l;
        bus.full = f;
        bus.data = d;
    endtask

    // One clock: drive, compare on the falling edge, advance the model on the rising edge.
    task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic f,
                       input logic [31:0] d);
        drive(r, l, f, d);
        @(negedge wclk);
        check_model();
        @(posedge wclk);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b0, 32'hA5A5A5A5);
        model_reset();
        @(posedge wclk);
        #1;
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        model_advance();
        #1;
    endtask

    initial begin
        logic [3:0]  r;
        logic [3:0]  l;
        logic        f;
        logic [31:0] d;

        // req, last, full | w_en, gnt, owner, busy, wdata  (data = 44332211)
        tbl[0] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00};
        tbl[1] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h33};
        tbl[2] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h33};
        tbl[3] = '{4'b0100, 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h33};
        tbl[4] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 8'h00};
        tbl[5] = '{4'b0011, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 8'h00};
        tbl[6] = '{4'b0011, 4'b0000, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11};
        tbl[7] = '{4'b0011, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 8'h11};
        tbl[8] = '{4'b0011, 4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11};
        tbl[9] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00};

        // Reset state, with live data so a zero wdata is meaningful.
        wrst_n = 1'b0;
        drive(4'b1111, 4'b0000, 1'b0, 32'hA5A5A5A5);
        #3;
        chk("reset w_en",  32'(bus.w_en),  32'd0);
        chk("reset gnt",   32'(bus.gnt),   32'd0);
        chk("reset wdata", 32'(bus.wdata), 32'd0);
        chk("reset owner", 32'(bus.owner), 32'd0);
        chk("reset busy",  32'(bus.busy),  32'd0);

        // Directed table: single requester with last, then wrap priority and a full stall.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].req, tbl[i].last, tbl[i].full, 32'h44332211);
            @(negedge wclk);
            chk($sformatf("tbl%0d w_en", i),  32'(bus.w_en),  32'(tbl[i].e_wen));
            chk($sformatf("tbl%0d gnt", i),   32'(bus.gnt),   32'(tbl[i].e_gnt));
            chk($sformatf("tbl%0d owner", i), 32'(bus.owner), 32'(tbl[i].e_owner));
            chk($sformatf("tbl%0d busy", i),  32'(bus.busy),  32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d wdata", i), 32'(bus.wdata), 32'(tbl[i].e_wdata));
            @(posedge wclk);
            model_advance();
            #1;
        end

        // Contention: all four requesting from reset, 25 cycles = 5 bursts of 4.
        do_reset();
        clear_counts();
        for (int i = 0; i < 25; i++) cyc(4'b1111, 4'b0000, 1'b0, 32'h44332211);
        chk("contention writes r0", 32'(wr_cnt[0]), 32'd8);
        chk("contention writes r1", 32'(wr_cnt[1]), 32'd4);
        chk("contention writes r2", 32'(wr_cnt[2]), 32'd4);
        chk("contention writes r3", 32'(wr_cnt[3]), 32'd4);

        // Full stall after two beats of requester 1, then exactly two more beats.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(4'b0010, 4'b0000, 1'b0, 32'h44332211);
        for (int i = 0; i < 5; i++) cyc(4'b0010, 4'b0000, 1'b1, 32'h44332211);
        clear_counts();
        for (int i = 0; i < 3; i++) cyc(4'b0010, 4'b0000, 1'b0, 32'h44332211);
        chk("stall remaining beats", 32'(wr_cnt[1]), 32'd2);
        chk("stall bubble busy", 32'(bus.busy), 32'd1);

        // Abandon: requester 0 drops req after one beat; pending requester 3 wins next.
        do_reset();
        cyc(4'b1001, 4'b0000, 1'b0, 32'h44332211);
        cyc(4'b1001, 4'b0000, 1'b0, 32'h44332211);
        cyc(4'b1000, 4'b0000, 1'b0, 32'h44332211);
        cyc(4'b1000, 4'b0000, 1'b0, 32'h44332211);
        #3;
        chk("abandon next owner", 32'(bus.owner), 32'd3);
        chk("abandon next busy",  32'(bus.busy),  32'd1);
        cyc(4'b1000, 4'b0000, 1'b0, 32'h44332211);

        // Reset during beat 2 of requester 3's burst.
        do_reset();
        cyc(4'b1000, 4'b0000, 1'b0, 32'h44332211);
        cyc(4'b1000, 4'b0000, 1'b0, 32'h44332211);
        @(negedge wclk);
        check_model();
        #1;
        wrst_n = 1'b0;
        #1;
        chk("midreset w_en",  32'(bus.w_en),  32'd0);
        chk("midreset gnt",   32'(bus.gnt),   32'd0);
        chk("midreset busy",  32'(bus.busy),  32'd0);
        chk("midreset owner", 32'(bus.owner), 32'd0);
        do_reset();
        cyc(4'b1001, 4'b0000, 1'b0, 32'h44332211);
        #3;
        chk("post-reset owner", 32'(bus.owner), 32'd0);
        cyc(4'b1001, 4'b0000, 1'b0, 32'h44332211);

        // Randomized run against the model; requests tend to be held across cycles.
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            f = ($urandom_range(0, 4) == 0);
            d = $urandom;
            cyc(r, l, f, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
